// File: rtl/cosine_pkg.sv
// cosine_pkg: fixed-point format and sizing shared by the cosine datapath
package cosine_pkg;
  localparam int FX_W = 16;
  localparam int FX_FRAC = 11;
  localparam int REQ_N = 4;
endpackage

// File: rtl/adder.sv
// adder: plain n-bit two's complement adder, wraps modulo 2^n
module adder #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] s
);
  assign s = a + b;
endmodule

// File: rtl/rr_select.sv
// rr_select: round-robin picker, first requester at or after ptr wins
module rr_select #(
  parameter int R = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] win
);
  logic hit;
  int idx;
  // scan ptr, ptr+1, ... modulo R and keep the first active request
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < R; k++) begin
      idx = (int'(ptr) + k) % R;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = IDW'(idx);
      end
    end
    gnt = hit ? R'(1) << win : '0;
  end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder among R requesters, round-robin, valid/ready result
module adder_arbiter
  import cosine_pkg::*;
#(
  parameter int N = FX_W,
  parameter int R = REQ_N,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] a_in,
  input  logic [R*N-1:0] b_in,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   result,
  output logic           result_ovf,
  output logic [IDW-1:0] result_id,
  output logic           result_valid,
  input  logic           result_ready
);
  logic [IDW-1:0] ptr, win;
  logic [R-1:0] pick;
  logic [N-1:0] a_sel, b_sel, sum;
  logic stall, accept, ovf;

  rr_select #(.R(R), .IDW(IDW)) u_sel (.req(req), .ptr(ptr), .gnt(pick), .win(win));

  assign stall = result_valid && !result_ready;
  assign gnt = (rst || stall) ? '0 : pick;
  assign accept = |gnt;
  assign a_sel = a_in[int'(win)*N +: N];
  assign b_sel = b_in[int'(win)*N +: N];

  adder #(.n(N)) u_add (.a(a_sel), .b(b_sel), .s(sum));

  assign ovf = (a_sel[N-1] == b_sel[N-1]) && (sum[N-1] != a_sel[N-1]);

  // capture the winner's sum, drop valid when popped with nothing new, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      result_ovf <= 1'b0;
      result_id <= '0;
      result_valid <= 1'b0;
      ptr <= '0;
    end else if (accept) begin
      result <= sum;
      result_ovf <= ovf;
      result_id <= win;
      result_valid <= 1'b1;
      ptr <= (win == IDW'(R-1)) ? '0 : win + 1'b1;
    end else if (!stall) begin
      result_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed table plus hand sequences for adder_arbiter
module tb_adder_arbiter;
  logic clk = 1'b0, rst = 1'b1, result_ready = 1'b1;
  logic [3:0] req = '0, gnt;
  logic [63:0] a_in = '0, b_in = '0;
  logic [15:0] result;
  logic result_ovf, result_valid;
  logic [1:0] result_id;
  int total = 0, bad = 0;

  adder_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .result(result), .result_ovf(result_ovf), .result_id(result_id),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [15:0] a, b;
    logic [3:0] gnt;
    logic [15:0] res;
    logic ovf;
    logic [1:0] id;
    logic vld;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    tv[0] = '{4'b0010, 16'h0C00, 16'h0C00, 4'b0010, 16'h1800, 1'b0, 2'd1, 1'b1};
    tv[1] = '{4'b0001, 16'h7FFF, 16'h0001, 4'b0001, 16'h8000, 1'b1, 2'd0, 1'b1};
    tv[2] = '{4'b1111, 16'hFFFF, 16'hFFFF, 4'b0010, 16'hFFFE, 1'b0, 2'd1, 1'b1};
    tv[3] = '{4'b1001, 16'h8000, 16'h8000, 4'b1000, 16'h0000, 1'b1, 2'd3, 1'b1};
    tv[4] = '{4'b1001, 16'h0100, 16'h0200, 4'b0001, 16'h0300, 1'b0, 2'd0, 1'b1};
    tv[5] = '{4'b1001, 16'hF000, 16'h0800, 4'b1000, 16'hF800, 1'b0, 2'd3, 1'b1};
    tv[6] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 16'hF800, 1'b0, 2'd3, 1'b0};
    tv[7] = '{4'b0100, 16'h4000, 16'h4000, 4'b0100, 16'h8000, 1'b1, 2'd2, 1'b1};

    req = 4'b1111;
    #1;
    chk("gnt_in_rst", 32'(gnt), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_id", 32'(result_id), 0);
    chk("rst_ovf", 32'(result_ovf), 0);
    req = '0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req = tv[i].req;
      for (int l = 0; l < 4; l++) begin
        a_in[l*16 +: 16] = tv[i].gnt[l] ? tv[i].a : 16'(16'h1111 * (l + 1));
        b_in[l*16 +: 16] = tv[i].gnt[l] ? tv[i].b : 16'(16'h0101 * (l + 1));
      end
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(result_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(tv[i].res));
      chk($sformatf("v%0d_ovf", i), 32'(result_ovf), 32'(tv[i].ovf));
      chk($sformatf("v%0d_id", i), 32'(result_id), 32'(tv[i].id));
      req = '0;
    end

    req = 4'b1111;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(result_valid), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_ovf", 32'(result_ovf), 0);
    chk("mid_rst_id", 32'(result_id), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int l = 0; l < 4; l++) begin
      a_in[l*16 +: 16] = 16'(l);
      b_in[l*16 +: 16] = 16'h0100;
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
      @(negedge clk);
      chk($sformatf("rr%0d_id", k), 32'(result_id), 32'(k % 4));
      chk($sformatf("rr%0d_result", k), 32'(result), 32'(16'h0100 + k % 4));
      chk($sformatf("rr%0d_valid", k), 32'(result_valid), 1);
    end

    result_ready = 1'b0;
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_gnt", k), 32'(gnt), 0);
      chk($sformatf("bp%0d_valid", k), 32'(result_valid), 1);
      chk($sformatf("bp%0d_id", k), 32'(result_id), 3);
      chk($sformatf("bp%0d_result", k), 32'(result), 32'h0103);
      @(negedge clk);
    end
    result_ready = 1'b1;
    #1;
    chk("pop_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    chk("pop_id", 32'(result_id), 0);
    chk("pop_result", 32'(result), 32'h0100);
    chk("pop_valid", 32'(result_valid), 1);
    #1;
    chk("next_gnt", 32'(gnt), 32'b0100);
    @(negedge clk);
    chk("next_id", 32'(result_id), 2);
    chk("next_result", 32'(result), 32'h0102);
    req = '0;
    @(negedge clk);
    chk("idle_valid", 32'(result_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one N-bit fixed-point adder (Q5.11 at default width) among R requesters in the cosine datapath. Each cycle it selects one pending requester round-robin, registers the sum with the winner's ID, and holds the result under a valid/ready handshake toward the consumer. It sits between the series-term generators and the single shared adder instance, so no requester needs its own adder.

## Interface
- N, 16, operand/result width (two's complement, Q5.11 at N=16)
- R, 4, number of requesters (2..8)
- IDW, $clog2(R), requester ID width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  R  per-requester operand valid; held with operands until granted
- a_in  in  R*N  operand A, requester i in bits [i*N +: N]
- b_in  in  R*N  operand B, same packing
- gnt  out  R  one-hot accept pulse; combinational; request i is consumed in the cycle gnt[i]=1
- result  out  N  registered sum
- result_ovf  out  1  signed overflow of that sum
- result_id  out  IDW  index of the requester that produced result
- result_valid  out  1  result/ovf/id are valid
- result_ready  in  1  consumer accepts result when result_valid && result_ready

## Operation
- stall = result_valid && !result_ready; while stall, gnt = 0 and nothing is accepted.
- Not stalled: winner = first i with req[i]=1 searching ptr, ptr+1, ..., wrapping modulo R. gnt[winner]=1; all other bits 0. No req -> gnt = 0.
- On accept: result <= a_in[w] + b_in[w] mod 2^N; result_ovf <= (sign a == sign b) && (sign result != sign a); result_id <= w; result_valid <= 1; ptr <= (w+1) mod R.
- No accept and not stalled: result_valid <= 0 (or stays 0). Result/ovf/id registers hold their last values.
- Accept and downstream pop in the same cycle is legal and gives full throughput: one result per cycle.
- ptr changes only on accept; a stall never moves it.
- Requester dropping req before grant is permitted; it is simply not selected.
- gnt forced to 0 while rst is high.

## Timing
- Reset values: result_valid=0, result=0, result_ovf=0, result_id=0, ptr=0.
- Latency: grant in cycle t -> result_valid=1 from cycle t+1.
- Throughput: 1 add/cycle with result_ready held high.
- Fairness: a continuously requesting input is granted within R accept cycles.
- Reset mid-operation: pending result discarded immediately (asynchronous clear); ptr returns to 0; requesters must re-present.
- gnt depends combinationally on req, ptr, result_valid, result_ready; no combinational path from a_in/b_in to any output.

## Structure
- Shared package cosine_pkg: fixed-point width constant (16), fraction bits (11), requester-count default.
- Sub-module rr_select: combinational round-robin picker (req, ptr -> one-hot gnt, winner index). The add itself instantiates the existing adder module with n=N; overflow logic lives in adder_arbiter.
- Expected size ~150 lines total.

## Test plan
- Reset: assert rst mid-stream with result_valid=1 -> result_valid, result, result_ovf, result_id all 0 in the same cycle; gnt=0 while rst high.
- Single request: req=4'b0010, a=0x0C00 (1.5), b=0x0C00 -> gnt=4'b0010 that cycle; next cycle result=0x1800 (3.0), result_id=1, result_ovf=0, result_valid=1.
- Round-robin: req=4'b1111 held, result_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and result_id 0,1,2,3,0,... one cycle later.
- Overflow/wrap: a=0x7FFF, b=0x0001 -> result=0x8000, result_ovf=1; a=0xFFFF, b=0xFFFF -> result=0xFFFE, result_ovf=0.
- Backpressure: result_valid=1, result_ready=0 for 3 cycles with req=4'b0101 -> gnt=0, result/id stable, ptr unchanged; on result_ready=1 the held result pops and the next winner is granted the same cycle.
- Wrap of pointer: last grant to requester 3, then req=4'b1001 -> requester 0 granted before requester 3.
